// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU issue path.
// Contents: datapath width default, ALU operation codes, MIPS opcode/funct
// encodings, issue FSM state type and the default-width issue bundle.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned REG_W   = 5;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd3;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'd4;

  // Primary opcodes (instruction [31:26])
  localparam logic [OP_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OPC_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OPC_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OPC_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OPC_LW    = 6'h23;
  localparam logic [OP_W-1:0] OPC_SW    = 6'h2B;

  // R-type function codes (instruction [5:0])
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } issue_state_t;

  // Issue bundle at the default datapath width
  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_W-1:0]   rd;
    logic               wb_en;
    logic               illegal;
  } issue_bundle_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode from raw instruction fields.
// Ports: opcode/funct in; aluop_c, b_imm_c (operand B from immediate),
// imm_sext_c (sign- vs zero-extend), wb_en_c, illegal_c out.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  output logic [ALUOP_W-1:0] aluop_c,
  output logic               b_imm_c,
  output logic               imm_sext_c,
  output logic               wb_en_c,
  output logic               illegal_c
);

  // Unsupported encodings fall through to ADD on rt with no writeback
  always_comb begin
    aluop_c    = ALU_ADD;
    b_imm_c    = 1'b0;
    imm_sext_c = 1'b1;
    wb_en_c    = 1'b0;
    illegal_c  = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        wb_en_c = 1'b1;
        case (funct)
          FN_ADD:  aluop_c = ALU_ADD;
          FN_SUB:  aluop_c = ALU_SUB;
          FN_AND:  aluop_c = ALU_AND;
          FN_OR:   aluop_c = ALU_OR;
          FN_SLT:  aluop_c = ALU_SLT;
          default: begin
            wb_en_c   = 1'b0;
            illegal_c = 1'b1;
          end
        endcase
      end
      OPC_ADDI: begin aluop_c = ALU_ADD; b_imm_c = 1'b1; wb_en_c = 1'b1; end
      OPC_SLTI: begin aluop_c = ALU_SLT; b_imm_c = 1'b1; wb_en_c = 1'b1; end
      OPC_LW:   begin aluop_c = ALU_ADD; b_imm_c = 1'b1; wb_en_c = 1'b1; end
      OPC_ANDI: begin
        aluop_c = ALU_AND; b_imm_c = 1'b1; imm_sext_c = 1'b0; wb_en_c = 1'b1;
      end
      OPC_ORI: begin
        aluop_c = ALU_OR; b_imm_c = 1'b1; imm_sext_c = 1'b0; wb_en_c = 1'b1;
      end
      OPC_SW:   begin aluop_c = ALU_ADD; b_imm_c = 1'b1; end
      OPC_BEQ:  aluop_c = ALU_SUB;
      default:  illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage toward the EX ALU: decodes ID fields into an operand bundle and
// presents it through a registered valid/ready stage with a one-entry skid.
// Ports: in_* handshake + instruction fields from ID, flush, out_* handshake
// + registered bundle (a, b, aluop, rd, wb_en, illegal) toward EX.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_opcode,
  input  logic [OP_W-1:0]      in_funct,
  input  logic [IMM_W-1:0]     in_imm,
  input  logic [WIDTH-1:0]     in_rs_val,
  input  logic [WIDTH-1:0]     in_rt_val,
  input  logic [REG_W-1:0]     in_rd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic [ALUOP_W-1:0]   out_aluop,
  output logic [REG_W-1:0]     out_rd,
  output logic                 out_wb_en,
  output logic                 out_illegal
);

  // Bundle at this instance's datapath width
  typedef struct packed {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_W-1:0]   rd;
    logic               wb_en;
    logic               illegal;
  } bundle_t;

  issue_state_t state, state_nxt;
  bundle_t      main_q, skid_q, in_bundle_c;

  logic [ALUOP_W-1:0] aluop_c;
  logic               b_imm_c, imm_sext_c, wb_en_c, illegal_c;
  logic [WIDTH-1:0]   imm_ext_c;
  logic               accept_c, out_hs_c;
  logic               load_main_in_c, load_skid_in_c, load_main_skid_c;

  alu_ctrl_decode u_decode (
    .opcode     (in_opcode),
    .funct      (in_funct),
    .aluop_c    (aluop_c),
    .b_imm_c    (b_imm_c),
    .imm_sext_c (imm_sext_c),
    .wb_en_c    (wb_en_c),
    .illegal_c  (illegal_c)
  );

  // Operand B assembly and incoming bundle
  always_comb begin
    imm_ext_c = imm_sext_c ? {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm}
                           : {{(WIDTH-IMM_W){1'b0}}, in_imm};
    in_bundle_c.a       = in_rs_val;
    in_bundle_c.b       = b_imm_c ? imm_ext_c : in_rt_val;
    in_bundle_c.aluop   = aluop_c;
    in_bundle_c.rd      = in_rd;
    in_bundle_c.wb_en   = wb_en_c;
    in_bundle_c.illegal = illegal_c;
  end

  assign accept_c = in_valid & in_ready;
  assign out_hs_c = out_valid & out_ready;

  // Next-state and register-load selection; flush overrides everything
  always_comb begin
    state_nxt        = state;
    load_main_in_c   = 1'b0;
    load_skid_in_c   = 1'b0;
    load_main_skid_c = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept_c) begin
            state_nxt      = ST_ONE;
            load_main_in_c = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_c && out_hs_c) begin
            load_main_in_c = 1'b1;
          end else if (accept_c) begin
            state_nxt      = ST_TWO;
            load_skid_in_c = 1'b1;
          end else if (out_hs_c) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_hs_c) begin
            state_nxt        = ST_ONE;
            load_main_skid_c = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State, handshake flags and bundle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      in_ready  <= (state_nxt != ST_TWO);
      if (load_main_in_c) begin
        main_q <= in_bundle_c;
      end else if (load_main_skid_c) begin
        main_q <= skid_q;
      end
      if (load_skid_in_c) begin
        skid_q <= in_bundle_c;
      end
    end
  end

  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_aluop   = main_q.aluop;
  assign out_rd      = main_q.rd;
  assign out_wb_en   = main_q.wb_en;
  assign out_illegal = main_q.illegal;

endmodule
